// File: rtl/ftoi_iter_pkg.sv
// svfloat: shared floating-point types for the FPU convert path.
// Holds the float32 layout, the rounding-mode encoding, the {nv, nx}
// exception flag pair and the rounding-increment decision.
package svfloat;

   localparam int F32_EW   = 8;
   localparam int F32_MW   = 23;
   localparam int F32_BIAS = 127;

   typedef struct packed {
      logic              sign;
      logic [F32_EW-1:0] exp;
      logic [F32_MW-1:0] man;
   } float32;

   // Encodings 101..111 are not named and round as RNE
   typedef enum logic [2:0] {
      RNE = 3'b000,
      RTZ = 3'b001,
      RDN = 3'b010,
      RUP = 3'b011,
      RMM = 3'b100
   } rmode_t;

   typedef struct packed {
      logic nv;
      logic nx;
   } fflags_t;

   // Decide whether the truncated magnitude must be bumped by one ulp
   function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                      input logic lsb, input logic guard,
                                      input logic sticky);
      logic inexact;
      inexact = guard | sticky;
      case (rm)
         RTZ:     round_inc = 1'b0;
         RDN:     round_inc = sign & inexact;
         RUP:     round_inc = ~sign & inexact;
         RMM:     round_inc = guard;
         default: round_inc = guard & (sticky | lsb);
      endcase
   endfunction

endpackage

// File: rtl/ftoi_iter_round.sv
// ftoi_round: combinational last stage of the float-to-int converter.
// Applies the rounding increment, checks the rounded magnitude against the
// target integer range, saturates out-of-range results and negates valid
// signed negative results. Exception flags exist only with
// SVFLOAT_FTOI_FLAGS_EN defined.
module ftoi_round
   import svfloat::*;
#(
   parameter int width = 32
) (
   input  logic [width-1:0] i_mag,
   input  logic             i_guard,
   input  logic             i_sticky,
   input  logic             i_sign,
   input  logic             i_issigned,
   input  logic [2:0]       i_rm,
   output logic [width-1:0] o_out
`ifdef SVFLOAT_FTOI_FLAGS_EN
   ,
   output fflags_t          o_flags
`endif
);

   // 2^(width-1) held in width+1 bits: largest negative magnitude allowed
   localparam logic [width:0]   LIM  = {2'b01, {(width-1){1'b0}}};
   localparam logic [width-1:0] SMAX = {1'b0, {(width-1){1'b1}}};
   localparam logic [width-1:0] SMIN = {1'b1, {(width-1){1'b0}}};
   localparam logic [width-1:0] UMAX = {width{1'b1}};

   logic           w_inc;
   logic [width:0] w_rnd;
   logic           w_ok;

   // Round, range-check, then either emit the value or saturate
   always_comb begin
      w_inc = round_inc(i_rm, i_sign, i_mag[0], i_guard, i_sticky);
      w_rnd = {1'b0, i_mag} + (width+1)'(w_inc);
      if (!i_issigned)
         w_ok = !w_rnd[width] && (!i_sign || (w_rnd == '0));
      else if (i_sign)
         w_ok = (w_rnd <= LIM);
      else
         w_ok = (w_rnd < LIM);

      if (w_ok)
         o_out = (i_issigned && i_sign) ? -w_rnd[width-1:0] : w_rnd[width-1:0];
      else if (i_sign)
         o_out = i_issigned ? SMIN : '0;
      else
         o_out = i_issigned ? SMAX : UMAX;
   end

`ifdef SVFLOAT_FTOI_FLAGS_EN
   // Saturation reports invalid only; otherwise inexact from guard/sticky
   always_comb begin
      o_flags.nv = !w_ok;
      o_flags.nx = w_ok & (i_guard | i_sticky);
   end
`endif

endmodule

// File: rtl/ftoi_iter.sv
// ftoi_iter: multi-cycle float32 to integer converter (FCVT.W[U] behaviour).
// The significand is shifted one bit per cycle toward its integer position,
// then rounded, range-checked and saturated in a single ROUND cycle.
// Handshake: an operand moves on in_valid && in_ready at a rising edge,
// a result moves on out_valid && out_ready at a rising edge; in_ready is high
// only in IDLE and out_valid only in DONE, so one operation is in flight.
// Optional feature: define SVFLOAT_FTOI_FLAGS_EN to get the {NV, NX} flags port.
module ftoi_iter
   import svfloat::*;
#(
   parameter int width = 32,
   parameter int frac  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  float32           in,
   input  logic             issigned,
   input  logic [2:0]       rm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [width-1:0] out,
   output logic [1:0]       o_state
`ifdef SVFLOAT_FTOI_FLAGS_EN
   ,
   output logic [1:0]       flags
`endif
);

   localparam int M      = F32_MW;
   localparam int MAG_W  = (width > M + 1) ? width : M + 1;
   localparam int MAXCNT = (width > M + 2) ? width : M + 2;
   localparam int CNT_W  = $clog2(MAXCNT + 1);

   localparam logic [width-1:0] SMAX = {1'b0, {(width-1){1'b1}}};
   localparam logic [width-1:0] SMIN = {1'b1, {(width-1){1'b0}}};
   localparam logic [width-1:0] UMAX = {width{1'b1}};

   typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

   state_t             r_state;
   logic [MAG_W-1:0]   r_mag;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_left;
   logic               r_guard;
   logic               r_sticky;
   logic               r_sign;
   logic               r_issigned;
   logic [2:0]         r_rm;
   logic               r_out_valid;
   logic [width-1:0]   r_out;
`ifdef SVFLOAT_FTOI_FLAGS_EN
   fflags_t            r_flags;
   fflags_t            w_rnd_flags;
`endif

   logic [M:0]         w_sig;
   int                 w_e;
   int                 w_shl;
   logic               w_nan;
   logic               w_inf;
   logic               w_special;
   logic               w_tiny;
   logic [width-1:0]   w_spec_out;
   logic [CNT_W-1:0]   w_cnt;
   logic [width-1:0]   w_rnd_out;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign out       = r_out;
   assign o_state   = r_state;
`ifdef SVFLOAT_FTOI_FLAGS_EN
   assign flags     = r_flags;
`endif

   // Decode the incoming operand: exponent, shift amount and special cases
   always_comb begin
      w_sig   = {(|in.exp), in.man};
      w_e     = (in.exp == '0) ? (1 - F32_BIAS) : (int'(in.exp) - F32_BIAS);
      w_shl   = w_e - M + frac;
      w_nan   = (&in.exp) && (|in.man);
      w_inf   = (&in.exp) && !(|in.man);
      // Infinity decodes to a huge exponent, so it is also caught by the range test
      w_special = w_nan || w_inf || ((w_e + frac) > (width - 1));
      w_tiny  = (w_shl < -(M + 2));
      if (w_nan || !in.sign)
         w_spec_out = issigned ? SMAX : UMAX;
      else
         w_spec_out = issigned ? SMIN : '0;
      w_cnt = (w_shl >= 0) ? CNT_W'(w_shl) : CNT_W'(-w_shl);
   end

   ftoi_round #(.width(width)) u_round (
      .i_mag      (r_mag[width-1:0]),
      .i_guard    (r_guard),
      .i_sticky   (r_sticky),
      .i_sign     (r_sign),
      .i_issigned (r_issigned),
      .i_rm       (r_rm),
      .o_out      (w_rnd_out)
`ifdef SVFLOAT_FTOI_FLAGS_EN
      ,
      .o_flags    (w_rnd_flags)
`endif
   );

   // Control FSM and datapath: accept, shift one bit per cycle, round, hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_mag       <= '0;
         r_cnt       <= '0;
         r_left      <= 1'b0;
         r_guard     <= 1'b0;
         r_sticky    <= 1'b0;
         r_sign      <= 1'b0;
         r_issigned  <= 1'b0;
         r_rm        <= 3'b000;
         r_out_valid <= 1'b0;
         r_out       <= '0;
`ifdef SVFLOAT_FTOI_FLAGS_EN
         r_flags     <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_sign     <= in.sign;
                  r_issigned <= issigned;
                  r_rm       <= rm;
                  r_guard    <= 1'b0;
                  r_sticky   <= 1'b0;
                  r_left     <= (w_shl >= 0);
                  r_cnt      <= '0;
                  if (w_special) begin
                     r_out       <= w_spec_out;
                     r_out_valid <= 1'b1;
`ifdef SVFLOAT_FTOI_FLAGS_EN
                     r_flags     <= '{nv: 1'b1, nx: 1'b0};
`endif
                     r_state     <= DONE;
                  end else if (w_tiny) begin
                     // Far below one ulp of the result: only stickiness survives
                     r_mag    <= '0;
                     r_sticky <= |w_sig;
                     r_state  <= ROUND;
                  end else begin
                     r_mag   <= MAG_W'(w_sig);
                     r_cnt   <= w_cnt;
                     r_state <= (w_cnt == '0) ? ROUND : SHIFT;
                  end
               end
            end
            SHIFT: begin
               if (r_left) begin
                  r_mag <= r_mag << 1;
               end else begin
                  r_mag    <= r_mag >> 1;
                  r_guard  <= r_mag[0];
                  r_sticky <= r_sticky | r_guard;
               end
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1))
                  r_state <= ROUND;
            end
            ROUND: begin
               r_out       <= w_rnd_out;
               r_out_valid <= 1'b1;
`ifdef SVFLOAT_FTOI_FLAGS_EN
               r_flags     <= w_rnd_flags;
`endif
               r_state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
